cnn_stream_loader: RTL and testbench



---
 rtl/cnn_stream_loader.sv | 213 +++++++++++++++++++++
 tb/tb_cnn_stream_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn_stream_loader.sv
// -----------------------------------------------------------------------------
// cnn_stream_loader
//
// Sequencer that feeds the CNN core's byte-serial load port. A start pulse
// makes it read KERNEL_WORDS conv weights, FC_WORDS FC weights and then an
// IMG_ROWS x IMG_COLS image (row-major) from a synchronous-read buffer. The
// weights go out in mode 0. The core gets a reset pulse, the mode switches to 1
// and the pixels follow, one byte per cycle.
//
// Optional feature macro: CNN_LOADER_CKSUM_EN
//   defined   -> cksum is a 16-bit running sum of every emitted byte
//                (sign-extended), cleared when a run starts
//   undefined -> cksum is tied to 0
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   single-cycle request to run one load sequence
//   busy       out  run in progress (through the last data cycle)
//   done       out  one-cycle pulse after the last image byte
//   mem_rd     out  buffer read enable
//   mem_addr   out  buffer read address
//   mem_rdata  in   buffer read data, valid the cycle after mem_rd
//   cnn_rst    out  reset pulse to the CNN core
//   cnn_mode   out  0 = weight load, 1 = image data
//   cnn_data   out  signed byte to the core's data_in (0 when not valid)
//   cnn_valid  out  cnn_data carries a real byte this cycle
//   cksum      out  running checksum (see macro above)
// -----------------------------------------------------------------------------
module cnn_stream_loader #(
    parameter int KERNEL_WORDS = 27,
    parameter int FC_WORDS     = 27,
    parameter int IMG_ROWS     = 11,
    parameter int IMG_COLS     = 12,
    parameter int ADDR_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [7:0]          mem_rdata,
    output logic                cnn_rst,
    output logic                cnn_mode,
    output logic signed [7:0]   cnn_data,
    output logic                cnn_valid,
    output logic [15:0]         cksum
);

    localparam int W    = KERNEL_WORDS + FC_WORDS;
    localparam int P    = IMG_ROWS * IMG_COLS;
    localparam int LAST = W + P + 4;
    localparam int CW   = $clog2(LAST + 2);

    // Run-relative cycle numbers (cycle 1 = PRE_RST).
    localparam logic [CW-1:0] C_W_LAST   = CW'(W);          // last weight fetch
    localparam logic [CW-1:0] C_I_FIRST  = CW'(W + 2);      // first image fetch
    localparam logic [CW-1:0] C_I_LAST   = CW'(W + P + 1);  // last image fetch
    localparam logic [CW-1:0] C_MID      = CW'(W + 3);      // core reset, mode -> 1
    localparam logic [CW-1:0] C_BUSY_END = CW'(W + P + 3);  // last pixel on the bus
    localparam logic [CW-1:0] C_FIN      = CW'(LAST);       // done pulse

    typedef enum logic [2:0] {
        IDLE,
        PRE_RST,
        WLOAD,
        MID_RST,
        IMG,
        FIN
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cyc_q, cyc_d, cyc_nxt;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                cnn_rst_q, cnn_rst_d;
    logic                cnn_mode_q, cnn_mode_d;
    logic                fetch_w, fetch_i;
    logic                start_acc;

    // Data pipeline: read issued -> data at buffer output -> registered onto bus.
    logic                rd_d1_q;
    logic                cnn_valid_q;
    logic signed [7:0]   cnn_data_q;

    // FIN behaves like IDLE for start so back-to-back runs need no gap.
    assign start_acc = start && ((state_q == IDLE) || (state_q == FIN));
    assign cyc_nxt   = cyc_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        cnn_rst_d  = 1'b0;
        cnn_mode_d = cnn_mode_q;
        fetch_w    = 1'b0;
        fetch_i    = 1'b0;

        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start_acc) begin
                    state_d    = PRE_RST;
                    cyc_d      = CW'(1);
                    busy_d     = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = '0;
                    cnn_rst_d  = 1'b1;
                    cnn_mode_d = 1'b0;
                end
            end
            default: begin
                // Everything in a run is scheduled off the cycle number of the
                // upcoming cycle; the one-cycle read bubble between the weight
                // and image fetches lines the mode switch up with the gap in
                // the output stream.
                cyc_d   = cyc_nxt;
                fetch_w = (cyc_nxt <= C_W_LAST);
                fetch_i = (cyc_nxt >= C_I_FIRST) && (cyc_nxt <= C_I_LAST);
                mem_rd_d = fetch_w || fetch_i;
                if (fetch_w) begin
                    mem_addr_d = ADDR_W'(cyc_nxt - 1'b1);
                end else if (fetch_i) begin
                    mem_addr_d = ADDR_W'(cyc_nxt - 2'd2);
                end
                busy_d    = (cyc_nxt <= C_BUSY_END);
                done_d    = (cyc_nxt == C_FIN);
                cnn_rst_d = (cyc_nxt == C_MID);
                if (cyc_nxt >= C_MID) begin
                    cnn_mode_d = 1'b1;
                end
                if (cyc_nxt == C_FIN) begin
                    state_d = FIN;
                end else if (cyc_nxt > C_MID) begin
                    state_d = IMG;
                end else if (cyc_nxt == C_MID) begin
                    state_d = MID_RST;
                end else begin
                    state_d = WLOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            cnn_rst_q  <= 1'b0;
            cnn_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            cnn_rst_q  <= cnn_rst_d;
            cnn_mode_q <= cnn_mode_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d1_q     <= 1'b0;
            cnn_valid_q <= 1'b0;
            cnn_data_q  <= '0;
        end else begin
            rd_d1_q     <= mem_rd_q;
            cnn_valid_q <= rd_d1_q;
            cnn_data_q  <= rd_d1_q ? mem_rdata : 8'd0;
        end
    end

`ifdef CNN_LOADER_CKSUM_EN
    logic [15:0] cksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum_q <= '0;
        end else if (start_acc) begin
            cksum_q <= '0;
        end else if (cnn_valid_q) begin
            cksum_q <= cksum_q + {{8{cnn_data_q[7]}}, cnn_data_q};
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = 16'd0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign cnn_rst   = cnn_rst_q;
    assign cnn_mode  = cnn_mode_q;
    assign cnn_data  = cnn_data_q;
    assign cnn_valid = cnn_valid_q;

endmodule

// File: tb/tb_cnn_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_cnn_stream_loader
//
// Directed bench for cnn_stream_loader with a synchronous-read buffer model.
// Expected bytes for a run are queued when start is driven and popped as the
// loader puts valid bytes on the bus; per-cycle control timing is checked
// against the run-relative cycle schedule.
// -----------------------------------------------------------------------------
module tb_cnn_stream_loader;

    localparam int KW = 27;
    localparam int FW = 27;
    localparam int R  = 11;
    localparam int C  = 12;
    localparam int AW = 8;
    localparam int W  = KW + FW;
    localparam int P  = R * C;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                busy, done, mem_rd, cnn_rst, cnn_mode, cnn_valid;
    logic [AW-1:0]       mem_addr;
    logic [7:0]          mem_rdata = 8'd0;
    logic signed [7:0]   cnn_data;
    logic [15:0]         cksum;

    logic [7:0]          mem [0:(1<<AW)-1];

    typedef struct {
        logic [7:0] data;
        logic       mode;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    cnn_stream_loader #(
        .KERNEL_WORDS (KW),
        .FC_WORDS     (FW),
        .IMG_ROWS     (R),
        .IMG_COLS     (C),
        .ADDR_W       (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .cnn_rst   (cnn_rst),
        .cnn_mode  (cnn_mode),
        .cnn_data  (cnn_data),
        .cnn_valid (cnn_valid),
        .cksum     (cksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  {31'd0, busy},      32'd0);
        check({tag, "_done"},  {31'd0, done},      32'd0);
        check({tag, "_rd"},    {31'd0, mem_rd},    32'd0);
        check({tag, "_addr"},  {24'd0, mem_addr},  32'd0);
        check({tag, "_crst"},  {31'd0, cnn_rst},   32'd0);
        check({tag, "_mode"},  {31'd0, cnn_mode},  32'd0);
        check({tag, "_data"},  {24'd0, cnn_data},  32'd0);
        check({tag, "_valid"}, {31'd0, cnn_valid}, 32'd0);
        check({tag, "_ck"},    {16'd0, cksum},     32'd0);
    endtask

    // Called at a negedge. Runs one load sequence and checks every cycle.
    // drive_start=0 means start was already sampled (chained run).
    task automatic run_seq(input string name, input bit drive_start, input int na, input int nb,
                           input int abort_at, input bit chain);
        exp_t        e;
        logic [15:0] ck;
        int          m0;
        int          m1;
        bit          e_rd, e_valid;
        int          e_addr;
        ck = '0;
        m0 = 0;
        m1 = 0;
        q.delete();
        for (int a = 0; a < W + P; a++) begin
            e.data = mem[a];
            e.mode = (a >= W);
            q.push_back(e);
            ck = ck + {{8{e.data[7]}}, e.data};
        end
        if (drive_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int n = 1; n <= W + P + 4; n++) begin
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                check_all_zero({name, "_abort"});
                @(negedge clk);
                rst = 1'b0;
                $display("%s: aborted at cycle %0d", name, n);
                return;
            end
            e_rd    = (n <= W) || (n >= W + 2 && n <= W + P + 1);
            e_addr  = (n <= W) ? n - 1 : n - 2;
            e_valid = (n >= 3 && n <= W + 2) || (n >= W + 4 && n <= W + P + 3);
            check({name, "_crst"},  {31'd0, cnn_rst},   {31'd0, (n == 1 || n == W + 3)});
            check({name, "_busy"},  {31'd0, busy},      {31'd0, (n <= W + P + 3)});
            check({name, "_done"},  {31'd0, done},      {31'd0, (n == W + P + 4)});
            check({name, "_mode"},  {31'd0, cnn_mode},  {31'd0, (n >= W + 3)});
            check({name, "_rd"},    {31'd0, mem_rd},    {31'd0, e_rd});
            check({name, "_valid"}, {31'd0, cnn_valid}, {31'd0, e_valid});
            if (e_rd) check({name, "_addr"}, {24'd0, mem_addr}, e_addr);
            if (cnn_valid) begin
                if (cnn_mode) m1++; else m0++;
            end
            if (e_valid) begin
                if (q.size() == 0) begin
                    check({name, "_qempty"}, 32'd0, 32'd1);
                end else begin
                    e = q.pop_front();
                    check({name, "_data"},  {24'd0, cnn_data}, {24'd0, e.data});
                    check({name, "_dmode"}, {31'd0, cnn_mode}, {31'd0, e.mode});
                end
            end else begin
                check({name, "_data0"}, {24'd0, cnn_data}, 32'd0);
            end
            if (n == W + P + 4) begin
                check({name, "_left"}, q.size(), 32'd0);
                check({name, "_n_m0"}, m0, W);
                check({name, "_n_m1"}, m1, P);
`ifdef CNN_LOADER_CKSUM_EN
                check({name, "_cksum"}, {16'd0, cksum}, {16'd0, ck});
`else
                check({name, "_cksum"}, {16'd0, cksum}, 32'd0);
`endif
                $display("%s: done at cycle %0d cksum=%0d model=%0d", name, n, cksum, ck);
                if (chain) start = 1'b1;
            end else if (n == na || n == nb) begin
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'd0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 3; k++)
                    mem[9*i + 3*j + k] = 8'(i + j + k);
        for (int m = 0; m < FW; m++) mem[KW + m] = 8'(m + 1);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                mem[W + C*r + c] = 8'(r + c + 1);

        // Reset behaviour.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst");
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_rel");
        for (int i = 0; i < 20; i++) begin
            check("idle_rd", {31'd0, mem_rd}, 32'd0);
            @(negedge clk);
        end
        $display("reset: idle checks complete");

        run_seq("full", 1'b1, 0, 0, 0, 1'b0);
        @(negedge clk);

        // start during busy ignored; start in FIN chains directly into a new run.
        run_seq("noise", 1'b1, 10, 100, 0, 1'b1);
        run_seq("chain", 1'b0, 0, 0, 0, 1'b0);
        @(negedge clk);

        // Abort mid-run, then a clean restart.
        run_seq("abort", 1'b1, 0, 0, 100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("post_abort_done", {31'd0, done}, 32'd0);
            check("post_abort_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        run_seq("restart", 1'b1, 0, 0, 0, 1'b0);
        @(negedge clk);

        // Negative byte passes through unmodified.
        mem[0] = 8'h80;
        run_seq("neg", 1'b1, 0, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
